// File: rtl/exe_pkg.sv
// Shared definitions for the EXE stage front end.
// Covers ALU operation codes, special register numbers and the
// control bundle that the ID/EX register carries.
package exe_pkg;

  // ALU operation codes. Bit 3 only distinguishes SRA from SRL.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // Register $0 is hardwired to zero. jal links into $31.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  // Decoded control that travels with an instruction from ID into EXE.
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic       jal;
    logic [3:0] aluc;
  } ctrl_t;

  // A bubble is an instruction that writes nothing.
  // The data fields of the ID/EX register are cleared alongside it.
  localparam ctrl_t BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, aluimm: 1'b0,
                               shift: 1'b0, jal: 1'b0, aluc: ALUC_ADD};

  // True when a write-back port targets register r.
  // A write to $0 never counts as a hit.
  function automatic logic wb_hits(input logic wen, input logic [7:0] rn, input logic [7:0] r);
    return wen && (rn == r) && (r != 8'(REG_ZERO));
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding selector for one source operand.
// If a newer result is in flight, that value replaces the latched
// register-file value. EX/MEM has priority over MEM/WB.
// A load sitting in EX/MEM has no data yet, so it is not forwarded.
module fwd_sel
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]   r,
  input  logic [XLEN-1:0] q,
  input  logic            m_wreg,
  input  logic            m_m2reg,
  input  logic [RW-1:0]   m_rn,
  input  logic [XLEN-1:0] m_alu,
  input  logic            w_wreg,
  input  logic [RW-1:0]   w_rn,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] f
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = wb_hits(m_wreg & ~m_m2reg, 8'(m_rn), 8'(r));
  assign wb_hit  = wb_hits(w_wreg, 8'(w_rn), 8'(r));

  // Pick the newest available value for register r.
  always_comb begin
    f = q;
    if (mem_hit) begin
      f = m_alu;
    end else if (wb_hit) begin
      f = w_data;
    end
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register and the operand-select front end of EXE.
// It latches decoded control and operands from ID and resolves forwarding.
// It then drives the ALU inputs and detects load-use hazards, which hold
// ID and insert a bubble into EXE.
module id_exe_stage
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic            d_wreg,
  input  logic            d_m2reg,
  input  logic            d_wmem,
  input  logic            d_aluimm,
  input  logic            d_shift,
  input  logic            d_jal,
  input  logic [3:0]      d_aluc,
  input  logic [RW-1:0]   d_rs,
  input  logic [RW-1:0]   d_rt,
  input  logic [RW-1:0]   d_rn,
  input  logic [XLEN-1:0] d_qa,
  input  logic [XLEN-1:0] d_qb,
  input  logic [XLEN-1:0] d_imm,
  input  logic [4:0]      d_sa,
  input  logic [XLEN-1:0] d_pc4,
  input  logic            m_wreg,
  input  logic            m_m2reg,
  input  logic [RW-1:0]   m_rn,
  input  logic [XLEN-1:0] m_alu,
  input  logic            w_wreg,
  input  logic [RW-1:0]   w_rn,
  input  logic [XLEN-1:0] w_data,
  output logic            ld_stall,
  output logic [XLEN-1:0] e_a,
  output logic [XLEN-1:0] e_b,
  output logic [3:0]      e_aluc,
  output logic            e_wreg,
  output logic            e_m2reg,
  output logic            e_wmem,
  output logic            e_jal,
  output logic [RW-1:0]   e_rn,
  output logic [XLEN-1:0] e_sdata,
  output logic [XLEN-1:0] e_pc8
);

  // ID/EX register contents
  ctrl_t           ctrl_q, ctrl_d;
  logic [RW-1:0]   rs_q, rs_d;
  logic [RW-1:0]   rt_q, rt_d;
  logic [RW-1:0]   rn_q, rn_d;
  logic [XLEN-1:0] qa_q, qa_d;
  logic [XLEN-1:0] qb_q, qb_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      sa_q, sa_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  ctrl_t           d_ctrl;
  logic            bubble;

  // Forwarding: index 0 is rs (ALU a side), index 1 is rt (b side / store data)
  logic [RW-1:0]   src_r [2];
  logic [XLEN-1:0] src_q [2];
  logic [XLEN-1:0] src_f [2];
  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;

  assign d_ctrl = '{wreg: d_wreg, m2reg: d_m2reg, wmem: d_wmem, aluimm: d_aluimm,
                    shift: d_shift, jal: d_jal, aluc: d_aluc};

  // A load in EXE has no data until it leaves MEM.
  // A consumer in ID has to wait one cycle. Both operands are compared even
  // when the instruction does not use rt, so some stalls are unnecessary.
  // Those stalls are harmless. A held pipeline never reports a stall.
  always_comb begin
    ld_stall = ctrl_q.m2reg && ctrl_q.wreg && (rn_q != '0) &&
               ((rn_q == d_rs) || (rn_q == d_rt)) && !hold;
  end

  assign bubble = flush | ld_stall;

  // Next ID/EX content: hold keeps it, a bubble clears it, otherwise load from ID
  always_comb begin
    ctrl_d = ctrl_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rn_d   = rn_q;
    qa_d   = qa_q;
    qb_d   = qb_q;
    imm_d  = imm_q;
    sa_d   = sa_q;
    pc4_d  = pc4_q;
    if (!hold) begin
      if (bubble) begin
        ctrl_d = BUBBLE;
        rs_d   = '0;
        rt_d   = '0;
        rn_d   = '0;
        qa_d   = '0;
        qb_d   = '0;
        imm_d  = '0;
        sa_d   = '0;
        pc4_d  = '0;
      end else begin
        ctrl_d = d_ctrl;
        rs_d   = d_rs;
        rt_d   = d_rt;
        rn_d   = d_rn;
        qa_d   = d_qa;
        qb_d   = d_qb;
        imm_d  = d_imm;
        sa_d   = d_sa;
        pc4_d  = d_pc4;
      end
    end
  end

  // ID/EX register. Reset gives the same empty state as a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= BUBBLE;
      rs_q   <= '0;
      rt_q   <= '0;
      rn_q   <= '0;
      qa_q   <= '0;
      qb_q   <= '0;
      imm_q  <= '0;
      sa_q   <= '0;
      pc4_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rn_q   <= rn_d;
      qa_q   <= qa_d;
      qb_q   <= qb_d;
      imm_q  <= imm_d;
      sa_q   <= sa_d;
      pc4_q  <= pc4_d;
    end
  end

  assign src_r[0] = rs_q;
  assign src_q[0] = qa_q;
  assign src_r[1] = rt_q;
  assign src_q[1] = qb_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel #(
        .XLEN (XLEN),
        .RW   (RW)
      ) u_fwd (
        .r       (src_r[gi]),
        .q       (src_q[gi]),
        .m_wreg  (m_wreg),
        .m_m2reg (m_m2reg),
        .m_rn    (m_rn),
        .m_alu   (m_alu),
        .w_wreg  (w_wreg),
        .w_rn    (w_rn),
        .w_data  (w_data),
        .f       (src_f[gi])
      );
    end
  endgenerate

  assign fa = src_f[0];
  assign fb = src_f[1];

  // ALU operand selection: the shift amount replaces rs, the immediate replaces rt
  always_comb begin
    e_a = ctrl_q.shift  ? {{(XLEN-5){1'b0}}, sa_q} : fa;
    e_b = ctrl_q.aluimm ? imm_q : fb;
  end

  assign e_sdata = fb;
  assign e_pc8   = pc4_q + XLEN'(4);
  assign e_aluc  = ctrl_q.aluc;
  assign e_wreg  = ctrl_q.wreg;
  assign e_m2reg = ctrl_q.m2reg;
  assign e_wmem  = ctrl_q.wmem;
  assign e_jal   = ctrl_q.jal;
  assign e_rn    = rn_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed testbench for id_exe_stage.
// Expected values are worked out by hand for each instruction step.
module tb_id_exe_stage;
  import exe_pkg::*;

  logic        clock;
  logic        reset, hold, flush;
  logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
  logic [3:0]  d_aluc;
  logic [4:0]  d_rs, d_rt, d_rn;
  logic [31:0] d_qa, d_qb, d_imm, d_pc4;
  logic [4:0]  d_sa;
  logic        m_wreg, m_m2reg;
  logic [4:0]  m_rn;
  logic [31:0] m_alu;
  logic        w_wreg;
  logic [4:0]  w_rn;
  logic [31:0] w_data;
  logic        ld_stall;
  logic [31:0] e_a, e_b, e_sdata, e_pc8;
  logic [3:0]  e_aluc;
  logic        e_wreg, e_m2reg, e_wmem, e_jal;
  logic [4:0]  e_rn;

  int n_cmp = 0;
  int n_err = 0;

  id_exe_stage #(.XLEN(32), .RW(5)) dut (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_aluimm(d_aluimm),
    .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
    .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .d_sa(d_sa), .d_pc4(d_pc4),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .ld_stall(ld_stall), .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_jal(e_jal),
    .e_rn(e_rn), .e_sdata(e_sdata), .e_pc8(e_pc8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 2 time units after the rising edge and are sampled 1 unit later
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_wb();
    m_wreg = 0; m_m2reg = 0; m_rn = 0; m_alu = 0;
    w_wreg = 0; w_rn = 0; w_data = 0;
  endtask

  initial begin
    reset = 1; hold = 0; flush = 0;
    d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_jal = 0;
    d_aluc = ALUC_ADD; d_rs = 0; d_rt = 0; d_rn = 0;
    d_qa = 0; d_qb = 0; d_imm = 0; d_sa = 0; d_pc4 = 0;
    clear_wb();

    // Reset
    tick(); tick();
    reset = 0; #1;
    $display("step reset: e_a=%h e_b=%h e_pc8=%h", e_a, e_b, e_pc8);
    check("rst_wreg", 32'(e_wreg), 0);
    check("rst_aluc", 32'(e_aluc), 0);
    check("rst_a", e_a, 0);
    check("rst_b", e_b, 0);
    check("rst_sdata", e_sdata, 0);
    check("rst_pc8", e_pc8, 32'h4);
    check("rst_stall", 32'(ld_stall), 0);

    // add $3,$1,$2
    d_wreg = 1; d_aluc = ALUC_ADD; d_rs = 1; d_rt = 2; d_rn = 3;
    d_qa = 5; d_qb = 7; d_pc4 = 32'h100;
    tick(); #1;
    $display("step add: e_a=%h e_b=%h e_rn=%0d", e_a, e_b, e_rn);
    check("add_a", e_a, 5);
    check("add_b", e_b, 7);
    check("add_rn", 32'(e_rn), 3);
    check("add_wreg", 32'(e_wreg), 1);
    check("add_pc8", e_pc8, 32'h104);

    // sub $4,$3,$1 with add's result in EX/MEM
    d_aluc = ALUC_SUB; d_rs = 3; d_rt = 1; d_rn = 4; d_qa = 0; d_qb = 5; d_pc4 = 32'h104;
    tick();
    m_wreg = 1; m_rn = 3; m_alu = 12; #1;
    $display("step sub: e_a=%h e_b=%h e_aluc=%h", e_a, e_b, e_aluc);
    check("sub_fwd_mem_a", e_a, 12);
    check("sub_b", e_b, 5);
    check("sub_aluc", 32'(e_aluc), 32'(ALUC_SUB));
    check("sub_sdata", e_sdata, 5);
    w_wreg = 1; w_rn = 3; w_data = 99; #1;
    check("mem_beats_wb", e_a, 12);
    m_m2reg = 1; #1;
    check("mem_load_no_fwd", e_a, 99);
    m_m2reg = 0; m_wreg = 0; #1;
    check("wb_fwd_a", e_a, 99);
    w_rn = 1; w_data = 32'h55; #1;
    check("wb_fwd_b", e_b, 32'h55);
    check("wb_fwd_sdata", e_sdata, 32'h55);
    check("wb_other_a", e_a, 0);

    // or $9,$0,$0 with writes to $0 in flight
    clear_wb();
    d_aluc = ALUC_OR; d_rs = 0; d_rt = 0; d_rn = 9; d_qa = 0; d_qb = 0;
    tick();
    m_wreg = 1; m_rn = 0; m_alu = 32'hDEAD; w_wreg = 1; w_rn = 0; w_data = 32'hBEEF; #1;
    $display("step or_r0: e_a=%h e_b=%h", e_a, e_b);
    check("r0_no_fwd_a", e_a, 0);
    check("r0_no_fwd_b", e_b, 0);
    clear_wb();

    // lw $5,8($1)
    d_m2reg = 1; d_aluimm = 1; d_aluc = ALUC_ADD; d_rs = 1; d_rt = 5; d_rn = 5;
    d_qa = 5; d_qb = 0; d_imm = 8;
    tick(); #1;
    $display("step lw5: e_b=%h e_m2reg=%0d", e_b, e_m2reg);
    check("lw_b_imm", e_b, 8);
    check("lw_m2reg", 32'(e_m2reg), 1);

    // add $6,$5,$1 right behind the load
    d_m2reg = 0; d_aluimm = 0; d_rs = 5; d_rt = 1; d_rn = 6; d_qa = 0; d_qb = 5; d_imm = 0; #1;
    $display("step add6 in ID: ld_stall=%0d", ld_stall);
    check("lu_stall", 32'(ld_stall), 1);
    tick(); #1;
    $display("step bubble: e_wreg=%0d e_rn=%0d", e_wreg, e_rn);
    check("lu_bubble_wreg", 32'(e_wreg), 0);
    check("lu_bubble_rn", 32'(e_rn), 0);
    check("lu_stall_clear", 32'(ld_stall), 0);
    tick();
    w_wreg = 1; w_rn = 5; w_data = 32'h1234; #1;
    $display("step add6 in EXE: e_a=%h e_b=%h", e_a, e_b);
    check("lu_wb_fwd_a", e_a, 32'h1234);
    check("lu_b", e_b, 5);
    check("lu_rn", 32'(e_rn), 6);
    clear_wb();

    // sll $7,$2,4
    d_shift = 1; d_sa = 4; d_aluc = ALUC_SLL; d_rs = 0; d_rt = 2; d_rn = 7; d_qa = 0; d_qb = 7;
    tick(); #1;
    $display("step sll: e_a=%h e_b=%h", e_a, e_b);
    check("sll_a", e_a, 4);
    check("sll_b", e_b, 7);
    check("sll_aluc", 32'(e_aluc), 32'(ALUC_SLL));

    // lui $8,0xABCD
    d_shift = 0; d_sa = 0; d_aluimm = 1; d_imm = 32'h0000ABCD; d_aluc = ALUC_LUI;
    d_rs = 0; d_rt = 8; d_rn = 8; d_qb = 0;
    tick(); #1;
    $display("step lui: e_b=%h e_aluc=%h", e_b, e_aluc);
    check("lui_b", e_b, 32'h0000ABCD);
    check("lui_aluc", 32'(e_aluc), 32'(ALUC_LUI));

    // lw $8,4($1), then a consumer of $8 through rt
    d_m2reg = 1; d_aluc = ALUC_ADD; d_rs = 1; d_rt = 8; d_rn = 8; d_imm = 4; d_qa = 5;
    tick();
    d_m2reg = 0; d_aluimm = 0; d_rs = 2; d_rt = 8; d_rn = 10; d_qa = 7; d_qb = 0; d_imm = 0; #1;
    $display("step add10 in ID: ld_stall=%0d", ld_stall);
    check("rt_stall", 32'(ld_stall), 1);
    hold = 1; flush = 1; #1;
    check("hold_no_stall", 32'(ld_stall), 0);
    tick(); #1;
    $display("step hold: e_rn=%0d e_m2reg=%0d", e_rn, e_m2reg);
    check("hold_m2reg", 32'(e_m2reg), 1);
    check("hold_rn", 32'(e_rn), 8);
    hold = 0; flush = 0; #1;
    check("unhold_stall", 32'(ld_stall), 1);
    tick(); #1;
    $display("step unhold bubble: e_wreg=%0d e_rn=%0d", e_wreg, e_rn);
    check("unhold_bubble_wreg", 32'(e_wreg), 0);
    check("unhold_bubble_rn", 32'(e_rn), 0);

    // Branch squash of the consumer
    flush = 1;
    tick(); #1;
    $display("step flush: e_wreg=%0d e_rn=%0d", e_wreg, e_rn);
    check("flush_wreg", 32'(e_wreg), 0);
    check("flush_rn", 32'(e_rn), 0);
    flush = 0;

    // jal at the top of the address space: the link value wraps
    d_jal = 1; d_wreg = 1; d_rn = 5'(REG_RA); d_rs = 0; d_rt = 0; d_pc4 = 32'hFFFF_FFFC;
    tick(); #1;
    $display("step jal: e_pc8=%h e_rn=%0d", e_pc8, e_rn);
    check("jal_flag", 32'(e_jal), 1);
    check("jal_rn", 32'(e_rn), 31);
    check("jal_pc8_wrap", e_pc8, 0);

    // Reset with jal in flight
    reset = 1;
    tick();
    reset = 0; #1;
    $display("step reset mid-op: e_jal=%0d e_pc8=%h", e_jal, e_pc8);
    check("rst2_jal", 32'(e_jal), 0);
    check("rst2_wreg", 32'(e_wreg), 0);
    check("rst2_rn", 32'(e_rn), 0);
    check("rst2_pc8", e_pc8, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
